// File: rtl/flag_pkg.sv
// flag_pkg: shared types and constants for the flag controller slice.
//   flag_pair_t  - one {C,Z} flag pair, live or shadowed
//   FLG_SRC_*    - load-source select encoding
//   flag_state_t - control FSM states
//   STK_OVF/UNF  - bit positions inside STK_ERR
package flag_pkg;

  typedef struct packed {
    logic c;
    logic z;
  } flag_pair_t;

  localparam logic FLG_SRC_ALU  = 1'b0;
  localparam logic FLG_SRC_SHAD = 1'b1;

  typedef enum logic {
    NORM = 1'b0,
    ERR  = 1'b1
  } flag_state_t;

  localparam int STK_OVF = 1;
  localparam int STK_UNF = 0;

endpackage

// File: rtl/flag_ctrl_if.sv
// flag_ctrl_if: strobe/flag bundle between the control unit, the ALU and
// flag_ctrl.
//   master - control unit / ALU side: drives strobes and ALU results,
//            observes the live flags and shadow-stack status
//   slave  - flag_ctrl side
// SHAD_CNT is $clog2(DEPTH+1) bits so that it can hold the value DEPTH.
interface flag_ctrl_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic          C_IN;
  logic          Z_IN;
  logic          FLG_LD_SEL;
  logic          FLG_C_LD;
  logic          FLG_C_SET;
  logic          FLG_C_CLR;
  logic          FLG_Z_LD;
  logic          INT_ENTRY;
  logic          RETI;
  logic          C_FLAG;
  logic          Z_FLAG;
  logic [CW-1:0] SHAD_CNT;
  logic          SHAD_FULL;
  logic          SHAD_EMPTY;
  logic [1:0]    STK_ERR;

  modport master (
    output C_IN, Z_IN, FLG_LD_SEL, FLG_C_LD, FLG_C_SET, FLG_C_CLR,
           FLG_Z_LD, INT_ENTRY, RETI,
    input  C_FLAG, Z_FLAG, SHAD_CNT, SHAD_FULL, SHAD_EMPTY, STK_ERR
  );

  modport slave (
    input  C_IN, Z_IN, FLG_LD_SEL, FLG_C_LD, FLG_C_SET, FLG_C_CLR,
           FLG_Z_LD, INT_ENTRY, RETI,
    output C_FLAG, Z_FLAG, SHAD_CNT, SHAD_FULL, SHAD_EMPTY, STK_ERR
  );

endinterface

// File: rtl/flag_stack.sv
// flag_stack: LIFO of flag_pair_t shadow entries.
//   clk, rst_n - clock, synchronous active-low reset (clears count only)
//   push, pop  - push din / pop top; both together on a non-empty stack
//                replaces the top with itself (contents and count unchanged),
//                both together on an empty stack behaves as a plain push
//   din        - value to push
//   top        - current top entry, 0 when empty
//   cnt        - occupied entries (saturates at 0 and DEPTH)
//   full/empty - combinational from cnt
module flag_stack
  import flag_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  flag_pair_t    din,
  output flag_pair_t    top,
  output logic [CW-1:0] cnt,
  output logic          full,
  output logic          empty
);

  flag_pair_t    mem_q [DEPTH];
  logic [CW-1:0] cnt_q, cnt_d;
  logic          wr_en;

  assign full  = (cnt_q == CW'(DEPTH));
  assign empty = (cnt_q == '0);
  assign cnt   = cnt_q;

  // A write only happens for a real push; the simultaneous pop+push on a
  // non-empty stack would rewrite the top with its own value, so it is skipped.
  assign wr_en = push && !full && (!pop || empty);

  always_comb begin
    cnt_d = cnt_q;
    if (wr_en) begin
      cnt_d = cnt_q + CW'(1);
    end else if (pop && !push && !empty) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_comb begin
    top = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (cnt_q == CW'(i + 1)) top = mem_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (wr_en && (cnt_q == CW'(i))) mem_q[i] <= din;
    end
  end

endmodule

// File: rtl/flag_ctrl.sv
// flag_ctrl: live C/Z status flags plus shadow stack for nested interrupts.
//   CLK   - system clock
//   RST_N - synchronous active-low reset
//   bus   - flag_ctrl_if.slave: strobes and ALU results in, live flags,
//           shadow count, full/empty and sticky STK_ERR {ovf,unf} out
// Optional build macro FLAG_STACK_ERR_EN: when defined, over/underflow is
// reported on STK_ERR and latches the ERR state; when undefined, STK_ERR
// reads 2'b00 and the FSM stays in NORM. Stack behaviour is identical.
//
// state | meaning
// NORM  | no stack error since reset
// ERR   | over/underflow seen since reset; left only by reset
module flag_ctrl
  import flag_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input logic       CLK,
  input logic       RST_N,
  flag_ctrl_if.slave bus
);

  localparam int CW = $clog2(DEPTH + 1);

  flag_pair_t    live_q, live_d;
  flag_pair_t    top;
  logic [CW-1:0] cnt;
  logic          full, empty, pop_ok;
  flag_state_t   state_q, state_d;
  logic [1:0]    err_q, err_d;

  flag_stack #(.DEPTH(DEPTH), .CW(CW)) u_stack (
    .clk   (CLK),
    .rst_n (RST_N),
    .push  (bus.INT_ENTRY),
    .pop   (bus.RETI),
    .din   (live_q),
    .top   (top),
    .cnt   (cnt),
    .full  (full),
    .empty (empty)
  );

  // Shadow-source loads peek the top without popping; top reads 0 when empty.
  always_comb begin
    pop_ok = bus.RETI && !empty;
    live_d = live_q;

    if (pop_ok)             live_d.c = top.c;
    else if (bus.FLG_C_SET) live_d.c = 1'b1;
    else if (bus.FLG_C_CLR) live_d.c = 1'b0;
    else if (bus.FLG_C_LD)
      live_d.c = (bus.FLG_LD_SEL == FLG_SRC_SHAD) ? top.c : bus.C_IN;

    if (pop_ok)             live_d.z = top.z;
    else if (bus.FLG_Z_LD)
      live_d.z = (bus.FLG_LD_SEL == FLG_SRC_SHAD) ? top.z : bus.Z_IN;
  end

`ifdef FLAG_STACK_ERR_EN
  logic ovf, unf;
  assign ovf = bus.INT_ENTRY && !bus.RETI && full;
  assign unf = bus.RETI && empty;
`endif

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
`ifdef FLAG_STACK_ERR_EN
    if (ovf || unf) state_d = ERR;
    err_d[STK_OVF] = err_q[STK_OVF] | ovf;
    err_d[STK_UNF] = err_q[STK_UNF] | unf;
`else
    state_d = NORM;
    err_d   = 2'b00;
`endif
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      live_q  <= '0;
      state_q <= NORM;
      err_q   <= 2'b00;
    end else begin
      live_q  <= live_d;
      state_q <= state_d;
      err_q   <= err_d;
    end
  end

  assign bus.C_FLAG     = live_q.c;
  assign bus.Z_FLAG     = live_q.z;
  assign bus.SHAD_CNT   = cnt;
  assign bus.SHAD_FULL  = full;
  assign bus.SHAD_EMPTY = empty;
  assign bus.STK_ERR    = (state_q == ERR) ? err_q : 2'b00;

endmodule

// File: tb/tb_flag_ctrl.sv
// tb_flag_ctrl: directed test-plan sequences followed by randomized strobes,
// checked against a queue-based reference model of the flag controller.
module tb_flag_ctrl;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  // reference model state
  bit       m_c, m_z;
  bit [1:0] m_stk[$];   // each entry {c,z}
  bit [1:0] m_err;      // {ovf,unf}

  flag_ctrl_if #(.DEPTH(DEPTH)) bus ();

  flag_ctrl #(.DEPTH(DEPTH)) dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model(input bit rst_b, set, clr, cld, zld, sel, cin, zin, ie, reti);
    bit       empty;
    bit [1:0] tp;
    bit       nc, nz;
    if (!rst_b) begin
      m_c = 0; m_z = 0; m_err = 2'b00;
      m_stk.delete();
      return;
    end
    empty = (m_stk.size() == 0);
    tp    = empty ? 2'b00 : m_stk[m_stk.size()-1];
    nc = m_c; nz = m_z;
    if (reti && !empty) begin
      nc = tp[1]; nz = tp[0];
    end else begin
      if (set)      nc = 1;
      else if (clr) nc = 0;
      else if (cld) nc = sel ? tp[1] : cin;
      if (zld)      nz = sel ? tp[0] : zin;
    end
    if (ie && reti) begin
      if (empty) begin
        m_stk.push_back({m_c, m_z});
        m_err[0] = 1;
      end
    end else if (ie) begin
      if (m_stk.size() < DEPTH) m_stk.push_back({m_c, m_z});
      else m_err[1] = 1;
    end else if (reti) begin
      if (!empty) void'(m_stk.pop_back());
      else m_err[0] = 1;
    end
    m_c = nc; m_z = nz;
  endtask

  task automatic check_all();
    bit [1:0] exp_err;
`ifdef FLAG_STACK_ERR_EN
    exp_err = m_err;
`else
    exp_err = 2'b00;
`endif
    chk("c_flag", 8'(bus.C_FLAG), 8'(m_c));
    chk("z_flag", 8'(bus.Z_FLAG), 8'(m_z));
    chk("shad_cnt", 8'(bus.SHAD_CNT), 8'(m_stk.size()));
    chk("shad_full", 8'(bus.SHAD_FULL), 8'(m_stk.size() == DEPTH));
    chk("shad_empty", 8'(bus.SHAD_EMPTY), 8'(m_stk.size() == 0));
    chk("stk_err", 8'(bus.STK_ERR), 8'(exp_err));
  endtask

  task automatic step(input bit rst_b, set, clr, cld, zld, sel, cin, zin, ie, reti);
    rst_n          = rst_b;
    bus.FLG_C_SET  = set;
    bus.FLG_C_CLR  = clr;
    bus.FLG_C_LD   = cld;
    bus.FLG_Z_LD   = zld;
    bus.FLG_LD_SEL = sel;
    bus.C_IN       = cin;
    bus.Z_IN       = zin;
    bus.INT_ENTRY  = ie;
    bus.RETI       = reti;
    @(posedge clk);
    model(rst_b, set, clr, cld, zld, sel, cin, zin, ie, reti);
    #1;
    check_all();
  endtask

  task automatic do_reset();  step(0, 0,0,0,0,0,0,0, 0,0); endtask
  task automatic push();      step(1, 0,0,0,0,0,0,0, 1,0); endtask
  task automatic pop();       step(1, 0,0,0,0,0,0,0, 0,1); endtask
  task automatic set_live(input bit c, input bit z);
    step(1, c, !c, 0, 1, 0, 0, z, 0, 0);
  endtask

  initial begin
    bit [1:0] exp_pairs [4];
    bit [1:0] unf_err;
`ifdef FLAG_STACK_ERR_EN
    unf_err = 2'b01;
`else
    unf_err = 2'b00;
`endif
    rst_n = 0;
    {bus.FLG_C_SET, bus.FLG_C_CLR, bus.FLG_C_LD, bus.FLG_Z_LD, bus.FLG_LD_SEL} = '0;
    {bus.C_IN, bus.Z_IN, bus.INT_ENTRY, bus.RETI} = '0;
    repeat (2) @(posedge clk);

    // set/clear/load priority
    do_reset();
    chk("rst_c", 8'(bus.C_FLAG), 8'h0);
    chk("rst_cnt", 8'(bus.SHAD_CNT), 8'h0);
    step(1, 1,1,0,0,0,0,0, 0,0);
    chk("set_over_clr", 8'(bus.C_FLAG), 8'h1);
    step(1, 0,1,0,0,0,0,0, 0,0);
    chk("clr", 8'(bus.C_FLAG), 8'h0);
    step(1, 0,0,1,0,0,1,0, 0,0);
    chk("ld_alu_c", 8'(bus.C_FLAG), 8'h1);
    chk("ld_alu_z", 8'(bus.Z_FLAG), 8'h0);

    // push with concurrent live strobes, then restore
    step(1, 0,1,0,1,0,0,1, 1,0);
    chk("ie_cz", 8'({bus.C_FLAG, bus.Z_FLAG}), 8'h1);
    chk("ie_cnt", 8'(bus.SHAD_CNT), 8'h1);
    pop();
    chk("reti_cz", 8'({bus.C_FLAG, bus.Z_FLAG}), 8'h2);
    chk("reti_empty", 8'(bus.SHAD_EMPTY), 8'h1);

    // fill, overflow, drain in LIFO order
    do_reset();
    exp_pairs = '{2'b10, 2'b01, 2'b11, 2'b00};
    for (int i = 0; i < 4; i++) begin
      set_live(exp_pairs[i][1], exp_pairs[i][0]);
      push();
    end
    chk("full", 8'(bus.SHAD_FULL), 8'h1);
    push();
    chk("ovf_cnt", 8'(bus.SHAD_CNT), 8'h4);
    for (int i = 3; i >= 0; i--) begin
      pop();
      chk("lifo_cz", 8'({bus.C_FLAG, bus.Z_FLAG}), 8'(exp_pairs[i]));
    end

    // underflow with C set
    do_reset();
    step(1, 1,0,0,0,0,0,0, 0,0);
    pop();
    chk("unf_c", 8'(bus.C_FLAG), 8'h1);
    chk("unf_err", 8'(bus.STK_ERR), 8'(unf_err));

    // simultaneous INT_ENTRY + RETI with top=11, live=00
    do_reset();
    push();
    set_live(1, 1);
    push();
    set_live(0, 0);
    step(1, 0,0,0,0,0,0,0, 1,1);
    chk("swap_cz", 8'({bus.C_FLAG, bus.Z_FLAG}), 8'h3);
    chk("swap_cnt", 8'(bus.SHAD_CNT), 8'h2);
    set_live(0, 0);
    pop();
    chk("swap_top", 8'({bus.C_FLAG, bus.Z_FLAG}), 8'h3);

    // shadow-source peek load
    step(1, 0,0,1,1,1,0,0, 0,0);

    // reset mid-nesting overrides RETI
    do_reset();
    set_live(1, 1);
    push(); push();
    step(0, 0,0,0,0,0,0,0, 0,1);
    chk("rst_mid_cnt", 8'(bus.SHAD_CNT), 8'h0);
    pop();
    chk("rst_mid_err", 8'(bus.STK_ERR), 8'(unf_err));

    // randomized strobes
    for (int n = 0; n < 600; n++) begin
      step($urandom_range(0, 59) != 0,
           $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
           $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
           $urandom_range(0, 1) == 1,
           $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
